// File: rtl/color_type_detect.sv
// color_type_detect: averages 2^SAMPLE_LOG2 RGB565 pixels per frame and classifies the dominant colour.
// Optional macro COLOR_DET_HYST_EN debounces color_type over STABLE_CNT matching measurements.
module color_type_detect #(
  parameter int SAMPLE_LOG2 = 10,
  parameter int BLACK_TH    = 6,
  parameter int WHITE_TH    = 25,
  parameter int DOM_MARGIN  = 6,
  parameter int STABLE_CNT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic [2:0]  color_type,
  output logic        meas_done,
  output logic        busy
);

  localparam int RBW = 5 + SAMPLE_LOG2;
  localparam int GW  = 6 + SAMPLE_LOG2;

  localparam logic [2:0] COLOR_INIT  = 3'd0;
  localparam logic [2:0] COLOR_BLACK = 3'd1;
  localparam logic [2:0] COLOR_WHITE = 3'd2;
  localparam logic [2:0] COLOR_RED   = 3'd3;
  localparam logic [2:0] COLOR_GREEN = 3'd4;
  localparam logic [2:0] COLOR_BLUE  = 3'd5;
  localparam logic [2:0] CLS_NONE    = 3'd7;

  localparam logic [GW-1:0] BLK_TH = GW'(BLACK_TH);
  localparam logic [GW-1:0] WHT_TH = GW'(WHITE_TH);
  localparam logic [GW-1:0] MARGIN = GW'(DOM_MARGIN);

  if (SAMPLE_LOG2 < 1 || STABLE_CNT < 1) begin : g_param_err
    $error("color_type_detect: SAMPLE_LOG2 and STABLE_CNT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_CLASSIFY,
    S_UPDATE
  } state_t;

  state_t                 state_q, state_d;
  logic [RBW-1:0]         sum_r_q, sum_r_d;
  logic [GW-1:0]          sum_g_q, sum_g_d;
  logic [RBW-1:0]         sum_b_q, sum_b_d;
  logic [SAMPLE_LOG2-1:0] cnt_q, cnt_d;
  logic [2:0]             cls_q, cls_d;
  logic [2:0]             color_q, color_d;
  logic                   done_q, done_d;

  logic [GW-1:0] avg_r, avg_g, avg_b;
  logic          r_dom, g_dom, b_dom;
  logic [2:0]    cls_w;

  // Averages are plain truncating shifts; green carries one extra bit.
  always_comb begin
    avg_r = GW'(sum_r_q >> SAMPLE_LOG2);
    avg_g = sum_g_q >> (SAMPLE_LOG2 + 1);
    avg_b = GW'(sum_b_q >> SAMPLE_LOG2);
    r_dom = (avg_r >= avg_g + MARGIN) && (avg_r >= avg_b + MARGIN);
    g_dom = (avg_g >= avg_r + MARGIN) && (avg_g >= avg_b + MARGIN);
    b_dom = (avg_b >= avg_r + MARGIN) && (avg_b >= avg_g + MARGIN);
    cls_w = CLS_NONE;
    if (avg_r < BLK_TH && avg_g < BLK_TH && avg_b < BLK_TH)
      cls_w = COLOR_BLACK;
    else if (avg_r > WHT_TH && avg_g > WHT_TH && avg_b > WHT_TH)
      cls_w = COLOR_WHITE;
    else if (r_dom)
      cls_w = COLOR_RED;
    else if (g_dom)
      cls_w = COLOR_GREEN;
    else if (b_dom)
      cls_w = COLOR_BLUE;
  end

`ifdef COLOR_DET_HYST_EN
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CNT);

  logic [2:0]    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
`endif

  always_comb begin
    state_d = state_q;
    sum_r_d = sum_r_q;
    sum_g_d = sum_g_q;
    sum_b_d = sum_b_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    color_d = color_q;
    done_d  = 1'b0;
`ifdef COLOR_DET_HYST_EN
    cand_d  = cand_q;
    stab_d  = stab_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          sum_r_d = '0;
          sum_g_d = '0;
          sum_b_d = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // A new frame restarts and wins over any sample this cycle.
        if (frame_start) begin
          sum_r_d = '0;
          sum_g_d = '0;
          sum_b_d = '0;
          cnt_d   = '0;
        end else if (pix_valid) begin
          sum_r_d = sum_r_q + RBW'(pix_data[15:11]);
          sum_g_d = sum_g_q + GW'(pix_data[10:5]);
          sum_b_d = sum_b_q + RBW'(pix_data[4:0]);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == '1)
            state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        cls_d   = cls_w;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef COLOR_DET_HYST_EN
        if (cls_q != CLS_NONE) begin
          if (cls_q == cand_q) begin
            if (stab_q != STAB_MAX)
              stab_d = stab_q + 1'b1;
          end else begin
            cand_d = cls_q;
            stab_d = SW'(1);
          end
          if (stab_d == STAB_MAX)
            color_d = cand_d;
        end
`else
        if (cls_q != CLS_NONE)
          color_d = cls_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sum_r_q <= '0;
      sum_g_q <= '0;
      sum_b_q <= '0;
      cnt_q   <= '0;
      cls_q   <= CLS_NONE;
      color_q <= COLOR_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_r_q <= sum_r_d;
      sum_g_q <= sum_g_d;
      sum_b_q <= sum_b_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

`ifdef COLOR_DET_HYST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_q <= COLOR_INIT;
      stab_q <= '0;
    end else begin
      cand_q <= cand_d;
      stab_q <= stab_d;
    end
  end
`endif

  assign color_type = color_q;
  assign meas_done  = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_color_type_detect.sv
// tb_color_type_detect: directed frames against a per-frame averaging model of color_type_detect.
// Literal expectations follow COLOR_DET_HYST_EN if it is defined for the build.
module tb_color_type_detect;

  localparam int NPIX = 16;
`ifdef COLOR_DET_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = 16'h0;
  logic [2:0]  color_type;
  logic        meas_done;
  logic        busy;

  int n_checks = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  color_type_detect #(
    .SAMPLE_LOG2(4),
    .BLACK_TH(6),
    .WHITE_TH(25),
    .DOM_MARGIN(6),
    .STABLE_CNT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .color_type(color_type),
    .meas_done(meas_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model: whole-frame integer sums, classification from the averages,
  // result visible two edges after the last accepted sample.
  bit         m_acc;
  int         m_n, m_sr, m_sg, m_sb;
  int         m_cd;
  int         m_res;
  int         m_cand, m_stab;
  logic [2:0] m_color;
  logic       m_done;
  logic       m_busy;

  function automatic int classify(int sr, int sg, int sb);
    int r, g, b;
    r = sr / NPIX;
    g = sg / (2 * NPIX);
    b = sb / NPIX;
    if (r < 6 && g < 6 && b < 6) return 1;
    if (r > 25 && g > 25 && b > 25) return 2;
    if (r >= g + 6 && r >= b + 6) return 3;
    if (g >= r + 6 && g >= b + 6) return 4;
    if (b >= r + 6 && b >= g + 6) return 5;
    return 7;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc = 0; m_n = 0; m_sr = 0; m_sg = 0; m_sb = 0;
      m_cd = 0; m_res = 7; m_cand = 0; m_stab = 0;
      m_color = 3'd0; m_done = 1'b0; m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          m_done = 1'b1;
          if (m_res != 7) begin
            if (HYST) begin
              if (m_res == m_cand) m_stab = (m_stab >= 2) ? 2 : m_stab + 1;
              else begin m_cand = m_res; m_stab = 1; end
              if (m_stab == 2) m_color = 3'(m_cand);
            end else begin
              m_color = 3'(m_res);
            end
          end
        end
      end else if (frame_start) begin
        m_acc = 1; m_n = 0; m_sr = 0; m_sg = 0; m_sb = 0;
      end else if (m_acc && pix_valid) begin
        m_sr += int'(pix_data[15:11]);
        m_sg += int'(pix_data[10:5]);
        m_sb += int'(pix_data[4:0]);
        m_n++;
        if (m_n == NPIX) begin
          m_acc = 0;
          m_cd = 2;
          m_res = classify(m_sr, m_sg, m_sb);
        end
      end
      m_busy = m_acc || (m_cd > 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_checks++;
      if ({color_type, meas_done, busy} === {m_color, m_done, m_busy}) n_pass++;
      else $display("FAIL model t=%0t: got type=%0d done=%0b busy=%0b expected type=%0d done=%0b busy=%0b",
                    $time, color_type, meas_done, busy, m_color, m_done, m_busy);
    end
  end

  task automatic start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pix(input logic [15:0] px, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        pix_valid = 1'b0;
        pix_data = 16'hFFFF;
        @(negedge clk);
      end
      pix_valid = 1'b1;
      pix_data = px;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    pix_data = 16'h0;
  endtask

  // Called right after the last sample; optionally holds frame_start
  // across CLASSIFY/UPDATE, where it must be dropped.
  task automatic done_chk(input string nm, input logic [2:0] c, input bit fs);
    frame_start = fs;
    @(negedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    chk({nm, "_done"}, int'(meas_done), 1);
    chk({nm, "_type"}, int'(color_type), int'(c));
    @(negedge clk);
  endtask

  task automatic frame(input string nm, input logic [15:0] px, input logic [2:0] c);
    start();
    pix(px, NPIX, 1'b0);
    done_chk(nm, c, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_type", int'(color_type), 0);
    chk("rst_done", int'(meas_done), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    frame("red1", 16'hF800, HYST ? 3'd0 : 3'd3);
    frame("red2", 16'hF800, 3'd3);
    frame("blk1", 16'h0000, HYST ? 3'd3 : 3'd1);
    frame("blk2", 16'h0000, 3'd1);
    frame("wht1", 16'hFFFF, HYST ? 3'd1 : 3'd2);
    frame("wht2", 16'hFFFF, 3'd2);
    frame("none1", 16'h8410, 3'd2);
    frame("blu1", 16'h001F, HYST ? 3'd2 : 3'd5);
    frame("none2", 16'h8410, HYST ? 3'd2 : 3'd5);

    start();
    pix(16'h001F, NPIX, 1'b0);
    done_chk("blu2", 3'd5, 1'b1);
    pix(16'h07E0, 5, 1'b0);
    chk("idle_busy", int'(busy), 0);

    start();
    pix(16'h07E0, 10, 1'b0);
    start();
    pix(16'h07E0, NPIX - 1, 1'b0);
    chk("restart_no_done", int'(meas_done), 0);
    pix(16'h07E0, 1, 1'b0);
    done_chk("grn_rst", HYST ? 3'd5 : 3'd4, 1'b0);

    start();
    pix(16'h07E0, NPIX, 1'b1);
    done_chk("grn_gap", 3'd4, 1'b0);

    start();
    pix(16'hF800, NPIX - 1, 1'b0);
    frame_start = 1'b1;
    pix(16'hF800, 1, 1'b0);
    frame_start = 1'b0;
    pix(16'h001F, NPIX, 1'b0);
    done_chk("coll_blu", HYST ? 3'd4 : 3'd5, 1'b0);

    start();
    pix(16'hF800, 5, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_type", int'(color_type), 0);
    chk("arst_done", int'(meas_done), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    frame("post1", 16'h07E0, HYST ? 3'd0 : 3'd4);
    frame("post2", 16'h07E0, 3'd4);

    repeat (4) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/color_type_detect.md
Name: color_type_detect

Overview:
- Classifies the dominant colour of the camera pixel stream into the 3-bit color_type code used by the seven-segment colour display and the filter datapath.
- Accepts RGB565 pixels from the capture path and accumulates 2^SAMPLE_LOG2 pixels per frame.
- Classifies the per-channel averages and publishes a debounced color_type once per frame.

Parameters:
- SAMPLE_LOG2, 10: log2 of the number of valid pixels accumulated per measurement.
- BLACK_TH, 6: every 5-bit channel average below this value classifies as BLACK.
- WHITE_TH, 25: every 5-bit channel average above this value classifies as WHITE.
- DOM_MARGIN, 6: the largest channel must exceed both other channels by at least this amount to classify as RED/GREEN/BLUE.
- STABLE_CNT, 2: number of consecutive identical classifications required before color_type changes.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous reset, active-low
- frame_start  input  1  one-cycle pulse at the start of each camera frame
- pix_valid  input  1  pix_data valid this cycle
- pix_data  input  16  RGB565: R[15:11], G[10:5], B[4:0]
- color_type  output  3  classified colour, params.v encoding: INIT=0, BLACK=1, WHITE=2, RED=3, GREEN=4, BLUE=5
- meas_done  output  1  one-cycle pulse when a measurement completes, whether or not color_type changed
- busy  output  1  high while in ACCUM, CLASSIFY or UPDATE

Behaviour:
- Reset state: color_type=COLOR_INIT (0), meas_done=0, busy=0, state=IDLE, sums/counters/stability counter cleared, candidate=COLOR_INIT.
- Reset takes effect asynchronously at any time, including mid-measurement; all partial sums are discarded.
- Channel widths:
  - sumR and sumB are 5+SAMPLE_LOG2 bits; sumG is 6+SAMPLE_LOG2 bits.
  - Averages are taken by right shift of SAMPLE_LOG2; no rounding.
  - G average is further shifted right by 1 to 5 bits before comparison.
- States:
  - IDLE: on frame_start, clear sums and sample counter, then go to ACCUM. pix_valid is ignored in IDLE.
  - ACCUM:
    - Each pix_valid cycle adds R/G/B to the sums and increments the counter.
    - On the edge accepting sample 2^SAMPLE_LOG2 (counter wraps to 0), go to CLASSIFY.
    - If frame_start arrives in ACCUM, restart: clear sums and counter, stay in ACCUM, and ignore pix_valid that cycle.
  - CLASSIFY: one cycle. The class is registered using the following priority:
    1. BLACK: all averages < BLACK_TH.
    2. WHITE: all averages > WHITE_TH.
    3. RED, GREEN or BLUE: that channel exceeds both others by >= DOM_MARGIN.
    4. NONE otherwise.
  - UPDATE: one cycle; meas_done=1.
    - If class==NONE: candidate and stability counter are unchanged, and color_type holds.
    - Else if class==candidate: the stability counter increments, saturating at STABLE_CNT.
    - Else: candidate<=class and counter<=1.
    - When the counter reaches STABLE_CNT, color_type<=candidate in the same cycle.
    - Then go to IDLE.
- Latency: color_type and meas_done update on the 2nd rising edge after the edge accepting the last sample.
- Rate and ordering:
  - At most one measurement per frame.
  - A frame_start arriving during CLASSIFY/UPDATE is dropped.
  - Measurement restarts only at the next frame_start after returning to IDLE.
- Simultaneous events: frame_start together with the final pix_valid in ACCUM: the restart wins and the sample is discarded.

Optional Feature:
- Macro: COLOR_DET_HYST_EN.
- Defined: stability filtering exactly as above, using STABLE_CNT.
- Undefined: candidate/counter logic is removed. In UPDATE, any non-NONE class is written to color_type immediately; NONE holds color_type.

Test Plan:
- Bench parameters: SAMPLE_LOG2=4, STABLE_CNT=2, HYST enabled.
- Reset check: assert rst=0 mid-ACCUM -> color_type=0, meas_done=0, busy=0 immediately. After release, the next frame starts a fresh accumulation with no residue.
- Red: two frames of 16 pixels at 16'hF800 -> meas_done pulses after each frame. color_type stays 0 after frame 1 and is 3 after frame 2, two edges after the 16th sample.
- Black then white:
  - Two frames of 16'h0000 -> color_type=1.
  - One frame of 16'hFFFF -> still 1.
  - Second frame of 16'hFFFF -> 2.
- Ambiguous and intermittent input:
  - A frame of 16'h8410 (R=16, G5=16, B=16) -> class NONE, color_type held, meas_done still pulses.
  - Sequence BLUE 16'h001F, NONE, BLUE -> color_type=5 after the second BLUE.
- Restart and gaps:
  - frame_start after 10 of 16 green pixels (16'h07E0) -> restart. Exactly 16 further samples are needed before meas_done.
  - Gaps in pix_valid do not change the sums.
- HYST disabled build: a single frame of 16'h07E0 -> color_type=4 after one measurement.
